// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: table of saturating counters indexed by PC (bimodal)
// or PC xor global history (gshare). Looked up combinationally in ID, trained
// in EX. After reset the table is swept to weakly-not-taken before the
// predictor reports ready. Keeps speculative history with mispredict repair
// and saturating branch/mispredict counters.
module gshare_branch_predictor #(
    parameter int PC_W  = 64,
    parameter int IDX_W = 6,
    parameter int CTR_W = 2,
    parameter int GHR_W = 6,
    parameter int MODE  = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    input  logic [GHR_W-1:0] upd_ghr,
    output logic             ready,
    output logic [CNT_W-1:0] n_branches,
    output logic [CNT_W-1:0] n_mispredicts
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [GHR_W-1:0]   ghr_q, ghr_d;
    logic [CTR_W-1:0]   table_q [ENTRIES];
    logic [CTR_W-1:0]   table_d [ENTRIES];
    logic [CNT_W-1:0]   n_br_q, n_br_d;
    logic [CNT_W-1:0]   n_mp_q, n_mp_d;
    logic [IDX_W-1:0]   pc_idx;
    logic [IDX_W-1:0]   lookup_idx;
    logic [CTR_W-1:0]   upd_ctr;
    logic               unused_pc_bits;

    // Only the word-index bits of the PC take part in the lookup.
    assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};

    // Lookup path: index formation and the taken prediction from the counter MSB.
    always_comb begin
        pc_idx = pred_pc[IDX_W+1:2];
        if (MODE == 1) begin
            lookup_idx = pc_idx ^ IDX_W'(ghr_q);
        end else begin
            lookup_idx = pc_idx;
        end
        pred_idx      = lookup_idx;
        pred_ghr      = ghr_q;
        ready         = (state_q == ST_RUN);
        pred_taken    = (state_q == ST_RUN) & table_q[lookup_idx][CTR_W-1];
        n_branches    = n_br_q;
        n_mispredicts = n_mp_q;
    end

    // Next-state: sweep the table in INIT; in RUN train counters, steer history, count.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        table_d = table_q;
        n_br_d  = n_br_q;
        n_mp_d  = n_mp_q;
        upd_ctr = table_q[upd_idx];
        case (state_q)
            ST_INIT: begin
                table_d[ptr_q] = WEAK_NT;
                ptr_d          = ptr_q + IDX_W'(1);
                if (ptr_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (upd_valid) begin
                    if (upd_taken) begin
                        if (upd_ctr != '1) begin
                            table_d[upd_idx] = upd_ctr + CTR_W'(1);
                        end
                    end else if (upd_ctr != '0) begin
                        table_d[upd_idx] = upd_ctr - CTR_W'(1);
                    end
                    if (n_br_q != '1) begin
                        n_br_d = n_br_q + CNT_W'(1);
                    end
                    if (upd_mispredict && (n_mp_q != '1)) begin
                        n_mp_d = n_mp_q + CNT_W'(1);
                    end
                end
                // A repair from EX overrides the speculative shift of a same-cycle lookup.
                if (upd_valid && upd_mispredict) begin
                    ghr_d = GHR_W'({upd_ghr, upd_taken});
                end else if (pred_valid) begin
                    ghr_d = GHR_W'({ghr_q, pred_taken});
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
            n_br_q  <= '0;
            n_mp_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
            n_br_q  <= n_br_d;
            n_mp_q  <= n_mp_d;
            table_q <= table_d;
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: drives directed and random traffic into a
// gshare predictor (CNT_W=4) and compares every cycle against a reference model.
module tb_gshare_branch_predictor;

    localparam int PC_W  = 64;
    localparam int IDX_W = 6;
    localparam int CTR_W = 2;
    localparam int GHR_W = 6;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             pred_valid;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic [GHR_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_mispredict;
    logic [GHR_W-1:0] upd_ghr;
    logic             ready;
    logic [CNT_W-1:0] n_branches;
    logic [CNT_W-1:0] n_mispredicts;

    gshare_branch_predictor #(
        .PC_W(PC_W), .IDX_W(IDX_W), .CTR_W(CTR_W),
        .GHR_W(GHR_W), .MODE(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_idx(pred_idx), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr),
        .ready(ready), .n_branches(n_branches), .n_mispredicts(n_mispredicts)
    );

    typedef struct {
        logic       exp_ready;
        logic       exp_taken;
        logic [5:0] exp_idx;
        logic [5:0] exp_ghr;
        logic [3:0] exp_nb;
        logic [3:0] exp_nm;
    } exp_t;

    exp_t sb[$];

    // Reference model: plain integers, table holds counter values 0..3.
    int m_tbl [64];
    int m_ghr;
    int m_init_left;
    int m_nb;
    int m_nm;
    bit m_valid;

    int checks;
    int failures;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compareField(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("ready", 64'(ready), 64'(e.exp_ready));
        compareField("pred_taken", 64'(pred_taken), 64'(e.exp_taken));
        compareField("pred_idx", 64'(pred_idx), 64'(e.exp_idx));
        compareField("pred_ghr", 64'(pred_ghr), 64'(e.exp_ghr));
        compareField("n_branches", 64'(n_branches), 64'(e.exp_nb));
        compareField("n_mispredicts", 64'(n_mispredicts), 64'(e.exp_nm));
    endtask

    // Monitor: the DUT presents a result every cycle; check it mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput(e);
        end
    end

    // One cycle of stimulus: drive, record what the DUT should show now, advance the model.
    task automatic applyStimulus(input bit rst_n, input bit pv, input logic [63:0] pc,
                                 input bit uv, input logic [5:0] uidx, input bit ut,
                                 input bit um, input logic [5:0] ughr);
        exp_t e;
        int   idx;
        bit   tk;
        @(posedge clk);
        #1;
        reset          = rst_n;
        pred_valid     = pv;
        pred_pc        = pc;
        upd_valid      = uv;
        upd_idx        = uidx;
        upd_taken      = ut;
        upd_mispredict = um;
        upd_ghr        = ughr;
        idx = int'((pc >> 2) & 64'd63) ^ m_ghr;
        tk  = (m_init_left == 0) && (m_tbl[idx] >= 2);
        if (m_valid) begin
            e.exp_ready = (m_init_left == 0);
            e.exp_taken = tk;
            e.exp_idx   = 6'(idx);
            e.exp_ghr   = 6'(m_ghr);
            e.exp_nb    = 4'(m_nb);
            e.exp_nm    = 4'(m_nm);
            sb.push_back(e);
        end
        if (!rst_n) begin
            m_valid     = 1'b1;
            m_ghr       = 0;
            m_init_left = 64;
            m_nb        = 0;
            m_nm        = 0;
        end else if (m_valid && m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0) begin
                for (int i = 0; i < 64; i++) m_tbl[i] = 1;
            end
        end else if (m_valid) begin
            if (uv) begin
                m_tbl[uidx] = ut ? ((m_tbl[uidx] < 3) ? m_tbl[uidx] + 1 : 3)
                                 : ((m_tbl[uidx] > 0) ? m_tbl[uidx] - 1 : 0);
                m_nb = (m_nb < 15) ? m_nb + 1 : 15;
                if (um) m_nm = (m_nm < 15) ? m_nm + 1 : 15;
            end
            if (uv && um) m_ghr = ((int'(ughr) << 1) | int'(ut)) & 63;
            else if (pv)  m_ghr = ((m_ghr << 1) | int'(tk)) & 63;
        end
    endtask

    task automatic idle(input logic [63:0] pc);
        applyStimulus(1'b1, 1'b0, pc, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    endtask

    // Walk the 64-cycle sweep; ready must be low on the 64th cycle and high on the 65th.
    task automatic sweepAndCheck();
        for (int i = 0; i < 64; i++) begin
            idle(64'h0);
            if (i == 63) begin
                #1 compareField("ready_low_at_64", 64'(ready), 64'd0);
            end
        end
        idle(64'h0);
        #1 compareField("ready_high_at_65", 64'(ready), 64'd1);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        m_valid        = 1'b0;
        m_ghr          = 0;
        m_init_left    = 0;
        m_nb           = 0;
        m_nm           = 0;
        for (int i = 0; i < 64; i++) m_tbl[i] = 0;
        reset          = 1'b0;
        pred_valid     = 1'b0;
        pred_pc        = '0;
        upd_valid      = 1'b0;
        upd_idx        = '0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        upd_ghr        = '0;

        // Reset, then the initialisation sweep.
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        sweepAndCheck();

        // Entry 5 trained up to saturation and back down; GHR is 0 so pc 0x14 reads entry 5.
        applyStimulus(1'b1, 1'b0, 64'h14, 1'b1, 6'd5, 1'b1, 1'b0, 6'd0);
        #1 compareField("e5_initial", 64'(pred_taken), 64'd0);
        applyStimulus(1'b1, 1'b0, 64'h14, 1'b1, 6'd5, 1'b1, 1'b0, 6'd0);
        #1 compareField("e5_after_1", 64'(pred_taken), 64'd1);
        applyStimulus(1'b1, 1'b0, 64'h14, 1'b1, 6'd5, 1'b1, 1'b0, 6'd0);
        applyStimulus(1'b1, 1'b0, 64'h14, 1'b1, 6'd5, 1'b0, 1'b0, 6'd0);
        idle(64'h14);
        #1 compareField("e5_after_nt", 64'(pred_taken), 64'd1);

        // Repair GHR to 000011, then gshare index for pc 0x40.
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 6'd20, 1'b1, 1'b1, 6'b000001);
        applyStimulus(1'b1, 1'b1, 64'h40, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        #1 compareField("gshare_idx", 64'(pred_idx), 64'h13);
        // Repair beats a same-cycle lookup.
        applyStimulus(1'b1, 1'b1, 64'h0, 1'b1, 6'd30, 1'b1, 1'b1, 6'b101010);
        #1 compareField("ghr_spec_shift", 64'(pred_ghr), 64'b000110);
        // Same-cycle lookup and update on entry 7.
        applyStimulus(1'b1, 1'b1, 64'h48, 1'b1, 6'd7, 1'b1, 1'b0, 6'd0);
        #1 compareField("ghr_repaired", 64'(pred_ghr), 64'b010101);
        compareField("e7_idx", 64'(pred_idx), 64'd7);
        compareField("e7_pre_update", 64'(pred_taken), 64'd0);
        idle(64'hB4);
        #1 compareField("e7_post_update", 64'(pred_taken), 64'd1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(($urandom_range(0, 199) != 0), 1'($urandom),
                          {$urandom, $urandom}, 1'($urandom),
                          6'($urandom_range(0, 15)), 1'($urandom),
                          1'($urandom), 6'($urandom));
        end

        // Reset mid-sweep restarts initialisation from entry 0.
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 30; i++) idle(64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        sweepAndCheck();

        // Twenty mispredicts saturate the 4-bit counters.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 6'($urandom_range(0, 63)),
                          1'($urandom), 1'b1, 6'($urandom));
        end
        idle(64'h0);
        #1 compareField("n_mispredicts_sat", 64'(n_mispredicts), 64'hF);
        compareField("n_branches_sat", 64'(n_branches), 64'hF);

        @(negedge clk);
        @(negedge clk);
        compareField("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
